risc_nb: RTL
============

Name: risc_nb

Overview:
- Parametrised successor of the 4-bit RISC sequencer: `DW`-bit datapath, instruction width `DW+8`, 16 registers, accumulator W with zero/carry flags.
- Adds a hardware return stack (CALL/RET) and a request/acknowledge RAM handshake that stalls the core.
- Sits between program ROM, external RAM and the serial/test pins; a testmode PC-stepping path is kept.

Parameters:
- DW, 4, data/register width; immediate field width.
- PAW, 12, program address width; must be >= DW+4 (elaboration error otherwise).
- STACK_DEPTH, 4, return stack entries (>=1).
- TIMEOUT_CYCLES, 16, RAM wait limit; used only with the optional feature.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- tm_en  in  1  testmode: execution frozen.
- tm_inc_pc  in  1  testmode: PC+1 per cycle while high.
- prog_addr  out  PAW  = PC.
- prog_data  in  DW+8  instruction IR, combinational from ROM.
- rxd  in  DW  sampled into R12.
- txd  out  DW  = R13.
- test  out  DW  = R15.
- ram_addr  out  2*DW  = {R7,R6}.
- ram_wdata  out  DW  = operand register, captured at request.
- ram_rdata  in  DW  valid when ram_ack is high.
- ram_req  out  1  RAM request, held until ack.
- ram_we  out  1  1 = write, valid with ram_req.
- ram_ack  in  1  one-cycle completion strobe.
- stack_err  out  1  sticky overflow/underflow flag.
- mem_err  out  1  sticky timeout flag (0 without the macro).

Behaviour:
- Reset: PC, R0..R15, W, Z, C, stack pointer, stack_err, mem_err, ram_req, ram_we all 0; state EXEC.
- IR fields:
  - op = IR[DW+7:DW+4]
  - f = IR[DW+3:DW]
  - n = IR[3:0] (register index)
  - imm = IR[DW-1:0]
  - tgt = IR[DW+3:0]
- PC+1 wraps modulo 2^PAW.
- EXEC, one instruction per cycle:
  - op 0..7 JMPC, cc = op[2:0]:
    - 000 always; 001 C; 010 C&!Z; 011 !Z; 100 never; 101 !C; 110 !C|Z; 111 Z.
    - Taken: PC[DW+3:0] <= tgt, upper PC bits kept. Not taken: PC+1.
  - 8 ALU reg: W <= W op(f) R[n]. 9 ALU imm: W <= W op(f) imm. Both then PC+1.
  - ALU ops:
    - 0 ADD: C = carry out.
    - 1 SUB: C = (W >= operand).
    - 2 AND, 3 OR, 4 XOR: C = 0.
    - 5 CMP: SUB flags only, W unchanged.
    - 6 LDW: W <= operand, C unchanged.
    - 7 SHL, 8 SHR: operand ignored, C = bit shifted out.
    - 9..15: no-op, flags unchanged.
    - Z = (result == 0) for every op 0..8.
  - C CALL: push PC+1, PC[DW+3:0] <= tgt. If stack full: stack_err <= 1, no push, PC+1.
  - D MOVI: R[f] <= imm; PC+1.
  - E RET: pop into PC. If stack empty: stack_err <= 1, PC+1.
  - F with f = 0, STO: ram_req <= 1, ram_we <= 1, ram_wdata <= R[n]; go to MEM_WAIT.
  - F with f = 1, LOAD: ram_req <= 1, ram_we <= 0; go to MEM_WAIT.
  - F with f = 2, MOVW: R[n] <= W; PC+1.
  - A, B and all other F encodings: NOP, PC+1.
- MEM_WAIT:
  - PC frozen; ram_addr and ram_wdata stable.
  - On ram_ack: ram_req <= 0; LOAD writes R[n] <= ram_rdata; PC+1; go to EXEC.
  - Ack arriving in the first cycle of ram_req high is legal.
- R12 <= rxd every EXEC cycle; an instruction write to R12 in the same cycle wins.
- tm_en is sampled only in EXEC. In MEM_WAIT it is ignored until ack.
- While tm_en is high: registers, W and flags hold; PC <= PC+1 when tm_inc_pc is high.
- Reset mid-MEM_WAIT: ram_req drops the next edge; the transaction is abandoned.

Optional Feature:
- RISC_NB_MEM_TIMEOUT_EN
  - Defined: a counter runs in MEM_WAIT. If no ack after TIMEOUT_CYCLES cycles: ram_req <= 0, mem_err <= 1, LOAD target unchanged, PC+1, go to EXEC.
  - Undefined: waits indefinitely; mem_err tied 0; no counter logic.

Decomposition:
- Package risc_nb_pkg holds:
  - opcode constants
  - ALU op constants
  - condition-code constants (CC_NC .. CC_EQ_ZS)
  - state enum {EXEC, MEM_WAIT}
- One sub-module, risc_nb_ret_stack: `STACK_DEPTH` x `PAW` LIFO with push, pop, full, empty. A simultaneous push and pop is not produced by the core.

Test Plan:
- Reset then MOVI R13,0x5 (DW=4): txd = 0x5 after 1 cycle; PC = 1.
- W=0x9, ALU imm ADD 0x8: W = 0x1, C = 1, Z = 0. Then JMPC cc=001 tgt=0x40: PC = 0x040.
- CALL 0x20 from PC 0x003, then RET: PC = 0x020, then 0x004. Five CALLs without RET (depth 4): stack_err = 1 and PC advances by 1 on the 5th.
- LOAD R2 with R7:R6 = 0xA5, ack after 3 cycles returning 0xC: ram_req high 3 cycles, PC frozen, R2 = 0xC, then PC+1.
- tm_en=1, tm_inc_pc=1 for 5 cycles during an ALU stream: PC +5, W unchanged. tm_en asserted mid-STO: the store completes on ack before freeze.
- With RISC_NB_MEM_TIMEOUT_EN and no ack: ram_req drops after 16 cycles, mem_err = 1, PC+1.

Source files
------------

// File: rtl/risc_nb_pkg.sv
// Shared constants for the risc_nb sequencer: opcodes, ALU ops, branch
// condition codes, core state encoding and the branch condition helper.
package risc_nb_pkg;

  localparam logic [3:0] OP_ALU_R = 4'h8;
  localparam logic [3:0] OP_ALU_I = 4'h9;
  localparam logic [3:0] OP_CALL  = 4'hC;
  localparam logic [3:0] OP_MOVI  = 4'hD;
  localparam logic [3:0] OP_RET   = 4'hE;
  localparam logic [3:0] OP_SYS   = 4'hF;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_CMP = 4'd5;
  localparam logic [3:0] ALU_LDW = 4'd6;
  localparam logic [3:0] ALU_SHL = 4'd7;
  localparam logic [3:0] ALU_SHR = 4'd8;

  // sub-function field of OP_SYS
  localparam logic [3:0] SYS_STO  = 4'd0;
  localparam logic [3:0] SYS_LOAD = 4'd1;
  localparam logic [3:0] SYS_MOVW = 4'd2;

  localparam logic [2:0] CC_NC    = 3'b000;
  localparam logic [2:0] CC_CS    = 3'b001;
  localparam logic [2:0] CC_HI    = 3'b010;
  localparam logic [2:0] CC_NE    = 3'b011;
  localparam logic [2:0] CC_NV    = 3'b100;
  localparam logic [2:0] CC_CC    = 3'b101;
  localparam logic [2:0] CC_LS    = 3'b110;
  localparam logic [2:0] CC_EQ_ZS = 3'b111;

  typedef enum logic {EXEC, MEM_WAIT} state_e;

  function automatic logic cc_taken(input logic [2:0] cc, input logic c, input logic z);
    logic t;
    case (cc)
      CC_NC:    t = 1'b1;
      CC_CS:    t = c;
      CC_HI:    t = c & ~z;
      CC_NE:    t = ~z;
      CC_NV:    t = 1'b0;
      CC_CC:    t = ~c;
      CC_LS:    t = ~c | z;
      default:  t = z;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/risc_nb_ret_stack.sv
// Return-address LIFO for CALL/RET; push is ignored when full, pop when empty.
module risc_nb_ret_stack #(
  parameter int DEPTH = 4,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] pop_data,
  output logic          full,
  output logic          empty
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SPW-1:0] sp_q, sp_d;
  logic [AW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  mem_d [DEPTH];
  logic [IW-1:0]  wr_idx, rd_idx;

  always_comb begin
    wr_idx   = IW'(sp_q);
    rd_idx   = IW'(sp_q - SPW'(1));
    full     = (sp_q == SPW'(DEPTH));
    empty    = (sp_q == '0);
    pop_data = mem_q[rd_idx];
    sp_d     = sp_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_idx] = push_data;
      sp_d          = sp_q + SPW'(1);
    end else if (pop && !empty) begin
      sp_d = sp_q - SPW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) sp_q <= '0;
    else       sp_q <= sp_d;
  end

  // entries beyond the pointer are never read, so storage needs no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/risc_nb.sv
// risc_nb: DW-bit accumulator sequencer with return stack and stalling RAM
// handshake. Define RISC_NB_MEM_TIMEOUT_EN to add the RAM wait timeout.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   EXEC     | one instruction per cycle, or testmode PC stepping
//   MEM_WAIT | STO/LOAD outstanding, ram_req held until ack (or timeout)
module risc_nb
  import risc_nb_pkg::*;
#(
  parameter int DW             = 4,
  parameter int PAW            = 12,
  parameter int STACK_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tm_en,
  input  logic            tm_inc_pc,
  output logic [PAW-1:0]  prog_addr,
  input  logic [DW+7:0]   prog_data,
  input  logic [DW-1:0]   rxd,
  output logic [DW-1:0]   txd,
  output logic [DW-1:0]   test,
  output logic [2*DW-1:0] ram_addr,
  output logic [DW-1:0]   ram_wdata,
  input  logic [DW-1:0]   ram_rdata,
  output logic            ram_req,
  output logic            ram_we,
  input  logic            ram_ack,
  output logic            stack_err,
  output logic            mem_err
);

  localparam int TW = DW + 4;
  localparam logic [PAW-1:0] TGT_MASK = PAW'({TW{1'b1}});

  if (PAW < DW + 4) begin : g_paw_chk
    $error("risc_nb: PAW must be >= DW+4");
  end
  if (STACK_DEPTH < 1) begin : g_depth_chk
    $error("risc_nb: STACK_DEPTH must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
    $error("risc_nb: TIMEOUT_CYCLES must be >= 1");
  end

  logic [3:0]    op, f, n;
  logic [DW-1:0] imm;
  logic [TW-1:0] tgt;

  assign op  = prog_data[DW+7:DW+4];
  assign f   = prog_data[DW+3:DW];
  assign n   = prog_data[3:0];
  assign imm = prog_data[DW-1:0];
  assign tgt = prog_data[DW+3:0];

  state_e         st_q, st_d;
  logic [PAW-1:0] pc_q, pc_d;
  logic [DW-1:0]  regs_q [16];
  logic [DW-1:0]  regs_d [16];
  logic [DW-1:0]  w_q, w_d;
  logic           z_q, z_d, c_q, c_d;
  logic           stack_err_q, stack_err_d;
  logic           ram_req_q, ram_req_d;
  logic           ram_we_q, ram_we_d;
  logic [DW-1:0]  ram_wdata_q, ram_wdata_d;
  logic [3:0]     mem_n_q, mem_n_d;

`ifdef RISC_NB_MEM_TIMEOUT_EN
  localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMW-1:0] tmr_q, tmr_d;
  logic           mem_err_q, mem_err_d;
`endif

  logic           stk_push, stk_pop, stk_full, stk_empty;
  logic [PAW-1:0] stk_top;
  logic [PAW-1:0] pc_inc, pc_tgt;

  assign pc_inc = pc_q + PAW'(1);
  assign pc_tgt = (pc_q & ~TGT_MASK) | PAW'(tgt);

  risc_nb_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .AW    (PAW)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .pop_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  logic [DW-1:0] opd, alu_res, alu_w;
  logic [DW:0]   add_x, sub_x;
  logic          alu_c, alu_z;

  // ALU result and flags; sub_x[DW] is the borrow, so C = ~borrow = (W >= opd)
  always_comb begin
    opd     = (op == OP_ALU_R) ? regs_q[n] : imm;
    add_x   = {1'b0, w_q} + {1'b0, opd};
    sub_x   = {1'b0, w_q} - {1'b0, opd};
    alu_res = '0;
    alu_w   = w_q;
    alu_c   = c_q;
    alu_z   = z_q;
    case (f)
      ALU_ADD: begin alu_res = add_x[DW-1:0]; alu_w = alu_res; alu_c = add_x[DW];  end
      ALU_SUB: begin alu_res = sub_x[DW-1:0]; alu_w = alu_res; alu_c = ~sub_x[DW]; end
      ALU_AND: begin alu_res = w_q & opd;     alu_w = alu_res; alu_c = 1'b0;       end
      ALU_OR:  begin alu_res = w_q | opd;     alu_w = alu_res; alu_c = 1'b0;       end
      ALU_XOR: begin alu_res = w_q ^ opd;     alu_w = alu_res; alu_c = 1'b0;       end
      ALU_CMP: begin alu_res = sub_x[DW-1:0]; alu_c = ~sub_x[DW];                  end
      ALU_LDW: begin alu_res = opd;           alu_w = alu_res;                     end
      ALU_SHL: begin alu_res = w_q << 1;      alu_w = alu_res; alu_c = w_q[DW-1];  end
      ALU_SHR: begin alu_res = w_q >> 1;      alu_w = alu_res; alu_c = w_q[0];     end
      default: ;
    endcase
    if (f <= ALU_SHR) alu_z = (alu_res == '0);
  end

  always_comb begin
    st_d        = st_q;
    pc_d        = pc_q;
    regs_d      = regs_q;
    w_d         = w_q;
    z_d         = z_q;
    c_d         = c_q;
    stack_err_d = stack_err_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_wdata_d = ram_wdata_q;
    mem_n_d     = mem_n_q;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
`ifdef RISC_NB_MEM_TIMEOUT_EN
    tmr_d       = tmr_q;
    mem_err_d   = mem_err_q;
`endif
    case (st_q)
      EXEC: begin
        if (tm_en) begin
          if (tm_inc_pc) pc_d = pc_inc;
        end else begin
          // rxd sampling comes first so an instruction write to R12 wins
          regs_d[12] = rxd;
          pc_d       = pc_inc;
          if (!op[3]) begin
            if (cc_taken(op[2:0], c_q, z_q)) pc_d = pc_tgt;
          end else begin
            case (op)
              OP_ALU_R, OP_ALU_I: begin
                w_d = alu_w;
                c_d = alu_c;
                z_d = alu_z;
              end
              OP_CALL: begin
                if (stk_full) begin
                  stack_err_d = 1'b1;
                end else begin
                  stk_push = 1'b1;
                  pc_d     = pc_tgt;
                end
              end
              OP_MOVI: regs_d[f] = imm;
              OP_RET: begin
                if (stk_empty) begin
                  stack_err_d = 1'b1;
                end else begin
                  stk_pop = 1'b1;
                  pc_d    = stk_top;
                end
              end
              OP_SYS: begin
                case (f)
                  SYS_STO, SYS_LOAD: begin
                    pc_d        = pc_q;
                    ram_req_d   = 1'b1;
                    ram_we_d    = (f == SYS_STO);
                    ram_wdata_d = regs_q[n];
                    mem_n_d     = n;
                    st_d        = MEM_WAIT;
`ifdef RISC_NB_MEM_TIMEOUT_EN
                    tmr_d       = TMW'(TIMEOUT_CYCLES - 1);
`endif
                  end
                  SYS_MOVW: regs_d[n] = w_q;
                  default: ;
                endcase
              end
              default: ;
            endcase
          end
        end
      end
      MEM_WAIT: begin
        if (ram_ack) begin
          ram_req_d = 1'b0;
          ram_we_d  = 1'b0;
          if (!ram_we_q) regs_d[mem_n_q] = ram_rdata;
          pc_d      = pc_inc;
          st_d      = EXEC;
        end
`ifdef RISC_NB_MEM_TIMEOUT_EN
        else if (tmr_q == '0) begin
          ram_req_d = 1'b0;
          ram_we_d  = 1'b0;
          mem_err_d = 1'b1;
          pc_d      = pc_inc;
          st_d      = EXEC;
        end else begin
          tmr_d = tmr_q - TMW'(1);
        end
`endif
      end
      default: st_d = EXEC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= EXEC;
      pc_q        <= '0;
      regs_q      <= '{default: '0};
      w_q         <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      stack_err_q <= 1'b0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      mem_n_q     <= '0;
`ifdef RISC_NB_MEM_TIMEOUT_EN
      tmr_q       <= '0;
      mem_err_q   <= 1'b0;
`endif
    end else begin
      st_q        <= st_d;
      pc_q        <= pc_d;
      regs_q      <= regs_d;
      w_q         <= w_d;
      z_q         <= z_d;
      c_q         <= c_d;
      stack_err_q <= stack_err_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      mem_n_q     <= mem_n_d;
`ifdef RISC_NB_MEM_TIMEOUT_EN
      tmr_q       <= tmr_d;
      mem_err_q   <= mem_err_d;
`endif
    end
  end

  assign prog_addr = pc_q;
  assign txd       = regs_q[13];
  assign test      = regs_q[15];
  assign ram_addr  = {regs_q[7], regs_q[6]};
  assign ram_wdata = ram_wdata_q;
  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign stack_err = stack_err_q;
`ifdef RISC_NB_MEM_TIMEOUT_EN
  assign mem_err   = mem_err_q;
`else
  assign mem_err   = 1'b0;
`endif

endmodule
